// File: rtl/complement_restore_unit.sv
`default_nettype none
// ============================================================================
// Module  : complement_restore_unit
// Brief   : Restores one's/two's-complemented words and queues them in a
//           small valid/ready FIFO together with an overflow flag.
// Revision: 1.0 - initial release
// ============================================================================
module complement_restore_unit #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4,
    parameter int CW    = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_ovf,
    output logic [CW-1:0]    level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [CW-1:0]    c_full     = CW'(DEPTH);
    localparam logic [WIDTH-1:0] c_most_neg = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] c_one      = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH:0]  r_mem [DEPTH];
    logic [AW-1:0]   r_wptr;
    logic [AW-1:0]   r_rptr;
    logic [CW-1:0]   r_level;
    logic            r_alive;

    logic [WIDTH-1:0] w_inv;
    logic [WIDTH-1:0] w_restored;
    logic             w_ovf;
    logic             w_push;
    logic             w_pop;

    assign w_inv      = ~in_data;
    assign w_restored = in_mode ? (w_inv + c_one) : w_inv;
    // Only the most-negative two's-complement value has no positive counterpart
    assign w_ovf      = in_mode & (in_data == c_most_neg);

    // r_alive holds in_ready low until the first clock after reset release
    assign in_ready  = r_alive & (r_level != c_full);
    assign out_valid = (r_level != '0);
    assign w_push    = in_valid & in_ready;
    assign w_pop     = out_valid & out_ready;

    assign out_data  = r_mem[r_rptr][WIDTH-1:0];
    assign out_ovf   = r_mem[r_rptr][WIDTH];
    assign level     = r_level;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
            r_alive <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            r_alive <= 1'b1;
            if (w_push) begin
                r_mem[r_wptr] <= {w_ovf, w_restored};
                r_wptr        <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_complement_restore_unit.sv
`default_nettype none
// ============================================================================
// Module  : tb_complement_restore_unit
// Brief   : Randomized and directed bench against a queue-based reference.
// Revision: 1.0 - initial release
// ============================================================================
module tb_complement_restore_unit;

    localparam int W  = 4;
    localparam int D  = 4;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_data = '0;
    logic          in_mode = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  out_data;
    logic          out_ovf;
    logic [CW-1:0] level;

    complement_restore_unit #(.WIDTH(W), .DEPTH(D), .CW(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ovf   (out_ovf),
        .level     (level)
    );

    always #5 clk = ~clk;

    int         total = 0;
    int         bad   = 0;
    logic [W:0] q[$];      // {ovf, data}
    bit         alive = 1'b0;
    bit         acc;

    function automatic logic [W:0] ref_restore(int x, bit m);
        int r;
        bit o;
        if (!m) begin
            r = (2**W - 1) - x;
            o = 1'b0;
        end else begin
            r = (2**W - x) % (2**W);
            o = (x == 2**(W-1));
        end
        return {o, W'(r)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic put(input bit v, input logic [W-1:0] d, input bit m, input bit r);
        in_valid  = v;
        in_data   = d;
        in_mode   = m;
        out_ready = r;
    endtask

    // Check outputs against the model, then advance one clock.
    task automatic step();
        bit         exp_ready, exp_valid, push, pop;
        logic [W:0] nw;
        logic [W:0] head;
        exp_ready = alive && (q.size() < D);
        exp_valid = (q.size() > 0);
        chk("in_ready", 32'(in_ready), 32'(exp_ready));
        chk("out_valid", 32'(out_valid), 32'(exp_valid));
        chk("level", 32'(level), 32'(q.size()));
        if (exp_valid) begin
            head = q[0];
            chk("out_data", 32'(out_data), 32'(head[W-1:0]));
            chk("out_ovf", 32'(out_ovf), 32'(head[W]));
        end
        push = rst_n && in_valid && exp_ready;
        pop  = rst_n && exp_valid && out_ready;
        nw   = push ? ref_restore(int'(in_data), in_mode) : '0;
        acc  = push;
        @(posedge clk);
        #1;
        if (pop)  void'(q.pop_front());
        if (push) q.push_back(nw);
        if (rst_n) alive = 1'b1;
    endtask

    logic [W-1:0] sweep [4];
    logic [W-1:0] fill  [5];

    initial begin
        sweep[0] = 4'b0001; sweep[1] = 4'b1111; sweep[2] = 4'b0000; sweep[3] = 4'b1000;
        fill[0] = 4'h3; fill[1] = 4'h8; fill[2] = 4'hC; fill[3] = 4'h0; fill[4] = 4'h5;

        // Reset values while held in reset
        #2;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_data", 32'(out_data), 0);
        chk("rst_out_ovf", 32'(out_ovf), 0);
        chk("rst_level", 32'(level), 0);
        chk("rst_in_ready", 32'(in_ready), 0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        #1;
        step();
        step();

        // One's complement single word
        put(1, 4'b1010, 0, 1);
        step();
        put(0, '0, 0, 1);
        step();
        step();

        // Two's complement sweep including zero and most-negative
        for (int i = 0; i < 4; i++) begin
            put(1, sweep[i], 1, 0);
            step();
        end
        put(0, '0, 0, 1);
        repeat (5) step();

        // Fill, backpressure, single pop, stall, drain
        begin
            int idx = 0;
            int cyc = 0;
            while (idx < 5 && cyc < 30) begin
                put(1, fill[idx], idx[0], (cyc == 6));
                step();
                if (acc) idx++;
                cyc++;
            end
            chk("fill_timeout", 32'(idx), 5);
        end
        put(0, '0, 0, 0);
        repeat (3) step();
        put(0, '0, 0, 1);
        repeat (6) step();

        // Throughput across pointer wrap
        for (int i = 0; i < 10; i++) begin
            put(1, W'($urandom), $urandom_range(0, 1), 1);
            step();
        end
        put(0, '0, 0, 1);
        repeat (3) step();

        // Asynchronous reset mid-stream with three words buffered
        for (int i = 0; i < 3; i++) begin
            put(1, W'(i + 9), 1, 0);
            step();
        end
        put(0, '0, 0, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", 32'(out_valid), 0);
        chk("mid_rst_level", 32'(level), 0);
        chk("mid_rst_in_ready", 32'(in_ready), 0);
        chk("mid_rst_out_data", 32'(out_data), 0);
        q.delete();
        alive = 1'b0;
        #5;
        step();
        #2 rst_n = 1'b1;
        step();
        step();
        put(1, 4'b0110, 1, 1);
        step();
        put(0, '0, 0, 1);
        repeat (3) step();

        // Randomized traffic; data is X whenever in_valid is low
        for (int i = 0; i < 500; i++) begin
            bit v;
            v = ($urandom_range(0, 3) != 0);
            put(v, v ? W'($urandom) : 'x, $urandom_range(0, 1), ($urandom_range(0, 2) != 0));
            step();
        end
        put(0, '0, 0, 1);
        repeat (6) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
